// File: rtl/morse_encoder.sv
// morse_encoder: Morse keyer. Takes dot / dash / letter-gap / word-gap requests
// over a valid/ready handshake and drives a timed on/off key line, one Morse
// time unit being UNIT_CYCLES clocks.
//
// Optional feature macro: MORSE_SIDETONE_EN
//   defined   -> a square-wave sidetone of half-period TONE_HALF_CYCLES is
//                produced on `tone` while key=1, restarted in phase per mark.
//   undefined -> `tone` is tied to 0 and no divider logic exists.
//
// Handshake: a symbol transfers on a rising edge where sym_valid & sym_ready.
// sym_ready is high only in IDLE and outside reset; sym is sampled only on
// that accepting edge, and the source may hold sym_valid across symbols to
// stream them back to back.
//
// Timing summary: the accepting edge loads the state, so key (for a mark) or
// busy (for a gap) is high from the following cycle. A symbol occupies
// (mark units + space units) * UNIT_CYCLES cycles, after which the FSM sits
// in IDLE with sym_ready=1 for at least the accepting cycle.
//
// Dot/dash are followed by one space unit (intra-character gap); the letter
// and word gaps supply 2 and 6 more units, giving net gaps of 3 and 7 units.

module morse_encoder #(
   parameter int UNIT_CYCLES      = 5_000_000,
   parameter int TONE_HALF_CYCLES = 50_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sym,
   input  logic       sym_valid,
   output logic       sym_ready,
   input  logic       abort,
   output logic       key,
   output logic       busy,
   output logic       tone,
   output logic [1:0] state_dbg
);

   // Symbol encodings on the sym input.
   localparam logic [1:0] SYM_DOT  = 2'b00;
   localparam logic [1:0] SYM_DASH = 2'b01;
   localparam logic [1:0] SYM_LG   = 2'b10;
   localparam logic [1:0] SYM_WG   = 2'b11;

   // Unit lengths of each phase.
   localparam logic [2:0] UNITS_DOT   = 3'd1;
   localparam logic [2:0] UNITS_DASH  = 3'd3;
   localparam logic [2:0] UNITS_LG    = 3'd2;
   localparam logic [2:0] UNITS_WG    = 3'd6;
   localparam logic [2:0] UNITS_INTRA = 3'd1;

   // Prescaler counts 0..UNIT_CYCLES-1; the terminal count is the unit tick.
   localparam int             PW         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [PW-1:0]  PRESC_LAST = PW'(UNIT_CYCLES - 1);

   // Elaboration-time sanity checks on the timing parameters.
   if (UNIT_CYCLES < 2) begin : g_bad_unit
      $error("morse_encoder: UNIT_CYCLES must be >= 2");
   end
   if (TONE_HALF_CYCLES < 1) begin : g_bad_tone
      $error("morse_encoder: TONE_HALF_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [2:0]     units_q, units_d;
   logic [PW-1:0]  presc_q, presc_d;
   logic           key_q, busy_q;
   logic           unit_tick;
   logic           accept;
   logic           key_d;

   assign unit_tick = (presc_q == PRESC_LAST);
   assign sym_ready = (state_q == IDLE) & ~reset;
   assign accept    = sym_valid & sym_ready;
   assign key_d     = (state_d == MARK);
   assign state_dbg = state_q;
   assign key       = key_q;
   assign busy      = busy_q;

   // Next-state logic: symbol acceptance, unit countdown, abort.
   always_comb begin
      state_d = state_q;
      units_d = units_q;
      presc_d = presc_q;
      unique case (state_q)
         IDLE: begin
            presc_d = '0;
            units_d = '0;
            if (accept) begin
               unique case (sym)
                  SYM_DOT: begin
                     state_d = MARK;
                     units_d = UNITS_DOT;
                  end
                  SYM_DASH: begin
                     state_d = MARK;
                     units_d = UNITS_DASH;
                  end
                  SYM_LG: begin
                     state_d = SPACE;
                     units_d = UNITS_LG;
                  end
                  SYM_WG: begin
                     state_d = SPACE;
                     units_d = UNITS_WG;
                  end
                  default: begin
                     state_d = IDLE;
                     units_d = '0;
                  end
               endcase
            end
         end
         MARK: begin
            if (abort) begin
               state_d = IDLE;
               units_d = '0;
               presc_d = '0;
            end else if (unit_tick) begin
               presc_d = '0;
               if (units_q == 3'd1) begin
                  // Last mark unit done: always follow with the intra-character gap.
                  state_d = SPACE;
                  units_d = UNITS_INTRA;
               end else begin
                  units_d = units_q - 3'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         SPACE: begin
            if (abort) begin
               state_d = IDLE;
               units_d = '0;
               presc_d = '0;
            end else if (unit_tick) begin
               presc_d = '0;
               if (units_q == 3'd1) begin
                  state_d = IDLE;
                  units_d = '0;
               end else begin
                  units_d = units_q - 3'd1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            units_d = '0;
            presc_d = '0;
         end
      endcase
   end

   // State, counters and registered key/busy; reset drops key immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         units_q <= '0;
         presc_q <= '0;
         key_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         units_q <= units_d;
         presc_q <= presc_d;
         key_q   <= key_d;
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef MORSE_SIDETONE_EN
   localparam int            TW        = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;
   localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF_CYCLES - 1);

   logic [TW-1:0] tone_cnt_q;
   logic          tone_q;

   assign tone = tone_q;

   // Sidetone divider: held clear outside a mark, and on the mark's first
   // edge, so tone first rises TONE_HALF_CYCLES cycles after key rises and
   // falls together with key.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else if (!key_d || !key_q) begin
         tone_cnt_q <= '0;
         tone_q     <= 1'b0;
      end else if (tone_cnt_q == TONE_LAST) begin
         tone_cnt_q <= '0;
         tone_q     <= ~tone_q;
      end else begin
         tone_cnt_q <= tone_cnt_q + 1'b1;
      end
   end
`else
   assign tone = 1'b0;
`endif

endmodule
